ped_req: RTL and testbench

- Pedestrian-side request unit; the other end of the traffic-light controller's pedestrian interface.
- Debounces the crossing push-button and drives the controller's request input N.
- Holds N until the controller grants walk (Pg), then enforces a lockout before accepting a new request.
- Monitors Pg/Pr consistency, drives the "WAIT" indicator and a wait-time counter for the display.

---
 rtl/ped_pkg.sv | 21 ++
 rtl/btn_debounce.sv | 61 ++++++
 rtl/ped_req.sv | 118 +++++++++++
 tb/tb_ped_req.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ped_pkg.sv
// Shared definitions for the pedestrian request unit: FSM encoding and default sizing.
package ped_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_SERVE = 2'd2,
        ST_LOCK  = 2'd3
    } ped_state_e;

    localparam int DEB_CYC_DEF  = 4;
    localparam int WAIT_W_DEF   = 8;
    localparam int MAX_WAIT_DEF = 200;
    localparam int LOCKOUT_DEF  = 16;

    // Bits needed to hold the values 0..n-1 (never less than one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer followed by a stability counter that
// moves the debounced level only after DEB_CYC consecutive disagreeing samples.
module btn_debounce
    import ped_pkg::*;
#(
    parameter int DEB_CYC = DEB_CYC_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam int CNT_W = cnt_width(DEB_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any sample that agrees with the current level restarts the stability count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/ped_req.sv
// Pedestrian-side request unit: raises N on a debounced press, holds it until walk is
// granted, then locks out new presses; also tracks wait time and lamp consistency.
module ped_req
    import ped_pkg::*;
#(
    parameter int DEB_CYC  = DEB_CYC_DEF,
    parameter int WAIT_W   = WAIT_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF,
    parameter int LOCKOUT  = LOCKOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn,
    input  logic              Pg,
    input  logic              Pr,
    output logic              N,
    output logic              wait_lamp,
    output logic [WAIT_W-1:0] wait_cnt,
    output logic              timeout,
    output logic              err
);

    localparam int LOCK_W = cnt_width(LOCKOUT);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT - 1);
    localparam logic [WAIT_W-1:0] MAX_W     = WAIT_W'(MAX_WAIT);

    ped_state_e        state_q;
    logic              n_q;
    logic              lamp_q;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    logic              tmo_q;
    logic              err_q;
    logic [LOCK_W-1:0] lock_q;
    logic              btn_lvl;
    logic              press;

    btn_debounce #(
        .DEB_CYC(DEB_CYC)
    ) u_deb (
        .clk_i  (clk),
        .rst_i  (rst),
        .btn_i  (btn),
        .level_o(btn_lvl),
        .press_o(press)
    );

    // Wait counter saturates rather than wrapping so the display never rolls back to 0.
    always_comb begin
        wait_d = wait_q;
        if (wait_q != {WAIT_W{1'b1}}) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            n_q     <= 1'b0;
            lamp_q  <= 1'b0;
            wait_q  <= '0;
            tmo_q   <= 1'b0;
            err_q   <= 1'b0;
            lock_q  <= '0;
        end else begin
            if (Pg == Pr) begin
                err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    // An active walk swallows a coincident press.
                    if (press && btn_lvl && !Pg) begin
                        state_q <= ST_REQ;
                        n_q     <= 1'b1;
                        lamp_q  <= 1'b1;
                        wait_q  <= '0;
                        tmo_q   <= (MAX_W == '0);
                    end
                end
                ST_REQ: begin
                    if (Pg) begin
                        state_q <= ST_SERVE;
                        n_q     <= 1'b0;
                        lamp_q  <= 1'b0;
                        tmo_q   <= 1'b0;
                    end else begin
                        wait_q <= wait_d;
                        tmo_q  <= (wait_d >= MAX_W);
                    end
                end
                ST_SERVE: begin
                    if (!Pg) begin
                        state_q <= ST_LOCK;
                        lock_q  <= LOCK_LAST;
                    end
                end
                ST_LOCK: begin
                    if (lock_q == '0) begin
                        state_q <= ST_IDLE;
                        wait_q  <= '0;
                    end else begin
                        lock_q <= lock_q - LOCK_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign N         = n_q;
    assign wait_lamp = lamp_q;
    assign wait_cnt  = wait_q;
    assign timeout   = tmo_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ped_req.sv
// Directed bench for ped_req with DEB_CYC=4, LOCKOUT=16, MAX_WAIT=20.
module tb_ped_req;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn;
    logic       Pg;
    logic       Pr;
    logic       N;
    logic       wait_lamp;
    logic [7:0] wait_cnt;
    logic       timeout;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ped_req #(
        .DEB_CYC (4),
        .WAIT_W  (8),
        .MAX_WAIT(20),
        .LOCKOUT (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .Pg       (Pg),
        .Pr       (Pr),
        .N        (N),
        .wait_lamp(wait_lamp),
        .wait_cnt (wait_cnt),
        .timeout  (timeout),
        .err      (err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic seen;

        rst = 1'b1;
        btn = 1'b0;
        Pg  = 1'b0;
        Pr  = 1'b1;
        #1;
        check_val("rst_N", 32'(N), 0);
        check_val("rst_lamp", 32'(wait_lamp), 0);
        check_val("rst_wait", 32'(wait_cnt), 0);
        check_val("rst_tmo", 32'(timeout), 0);
        check_val("rst_err", 32'(err), 0);
        tick(2);
        rst = 1'b0;
        tick(3);

        // Clean press: N rises on the 7th edge after btn rises.
        btn  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            seen |= N;
        end
        check_val("press_N_early", 32'(seen), 0);
        tick(1);
        check_val("press_N", 32'(N), 1);
        check_val("press_lamp", 32'(wait_lamp), 1);
        check_val("press_wait0", 32'(wait_cnt), 0);
        tick(2);
        check_val("press_wait2", 32'(wait_cnt), 2);
        check_val("press_tmo", 32'(timeout), 0);

        // Service at wait_cnt=10.
        tick(8);
        check_val("svc_wait10", 32'(wait_cnt), 10);
        Pg = 1'b1;
        Pr = 1'b0;
        tick(1);
        check_val("svc_N", 32'(N), 0);
        check_val("svc_lamp", 32'(wait_lamp), 0);
        check_val("svc_wait_hold", 32'(wait_cnt), 10);
        btn = 1'b0;
        tick(1);
        Pg = 1'b0;
        Pr = 1'b1;
        tick(1);
        tick(5);
        btn  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            seen |= N;
        end
        check_val("lock_press_ignored", 32'(seen), 0);
        check_val("lock_wait_hold", 32'(wait_cnt), 10);
        tick(1);
        check_val("lock_end_wait0", 32'(wait_cnt), 0);
        tick(4);
        check_val("lock_no_queue", 32'(N), 0);

        // Fresh press after lockout.
        btn = 1'b0;
        tick(8);
        btn  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            seen |= N;
        end
        check_val("repress_N_early", 32'(seen), 0);
        tick(1);
        check_val("repress_N", 32'(N), 1);
        btn = 1'b0;

        // Timeout at wait_cnt >= 20.
        tick(19);
        check_val("tmo_wait19", 32'(wait_cnt), 19);
        check_val("tmo_off19", 32'(timeout), 0);
        tick(1);
        check_val("tmo_on20", 32'(timeout), 1);
        tick(5);
        check_val("tmo_wait25", 32'(wait_cnt), 25);
        check_val("tmo_on25", 32'(timeout), 1);
        Pg = 1'b1;
        Pr = 1'b0;
        tick(1);
        check_val("tmo_clear", 32'(timeout), 0);
        check_val("tmo_svc_N", 32'(N), 0);
        check_val("tmo_svc_wait", 32'(wait_cnt), 25);
        Pg = 1'b0;
        Pr = 1'b1;
        tick(18);
        check_val("tmo_idle_wait0", 32'(wait_cnt), 0);

        // Bounce: toggle every 2 cycles for 20 cycles, then settle low.
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            btn = 1'b1;
            tick(1); seen |= N | wait_lamp;
            tick(1); seen |= N | wait_lamp;
            btn = 1'b0;
            tick(1); seen |= N | wait_lamp;
            tick(1); seen |= N | wait_lamp;
        end
        for (int i = 0; i < 10; i++) begin
            tick(1);
            seen |= N | wait_lamp;
        end
        check_val("bounce_no_N", 32'(seen), 0);
        check_val("bounce_wait0", 32'(wait_cnt), 0);

        // Press coinciding with an unrequested walk is dropped.
        Pg   = 1'b1;
        Pr   = 1'b0;
        btn  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            seen |= N;
        end
        check_val("pg_prio_N", 32'(seen), 0);
        Pg = 1'b0;
        Pr = 1'b1;
        tick(5);
        check_val("pg_prio_after", 32'(N), 0);
        check_val("pre_fault_err", 32'(err), 0);
        btn = 1'b0;
        tick(8);

        // Lamp fault: both lit for one cycle.
        Pg = 1'b1;
        Pr = 1'b1;
        tick(1);
        Pg = 1'b0;
        Pr = 1'b1;
        check_val("fault_err", 32'(err), 1);
        check_val("fault_N", 32'(N), 0);
        tick(5);
        check_val("fault_sticky", 32'(err), 1);

        // Async reset in the middle of a request.
        btn = 1'b1;
        tick(7);
        check_val("ar_req_N", 32'(N), 1);
        tick(3);
        #3;
        rst = 1'b1;
        #1;
        check_val("ar_N", 32'(N), 0);
        check_val("ar_lamp", 32'(wait_lamp), 0);
        check_val("ar_wait", 32'(wait_cnt), 0);
        check_val("ar_err", 32'(err), 0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            seen |= N;
        end
        check_val("ar_held_N", 32'(seen), 0);
        tick(1);
        check_val("ar_new_edge_N", 32'(N), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
